// File: rtl/dmem_arbiter_if.sv
// Request/response and memory-side bundle shared by the arbiter and the two requesters.
// The slave view belongs to the arbiter; the master view drives requests and models the memory.
interface dmem_arbiter_if #(
  parameter int AW = 32,
  parameter int DW = 32
);
  logic          req0_valid;
  logic          req0_ready;
  logic [AW-1:0] req0_addr;
  logic [DW-1:0] req0_wdata;
  logic          req0_we;
  logic          rsp0_valid;
  logic [DW-1:0] rsp0_rdata;

  logic          req1_valid;
  logic          req1_ready;
  logic [AW-1:0] req1_addr;
  logic [DW-1:0] req1_wdata;
  logic          req1_we;
  logic          rsp1_valid;
  logic [DW-1:0] rsp1_rdata;

  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic          mem_we;
  logic [DW-1:0] mem_rdata;

  modport slave (
    input  req0_valid, req0_addr, req0_wdata, req0_we,
    output req0_ready, rsp0_valid, rsp0_rdata,
    input  req1_valid, req1_addr, req1_wdata, req1_we,
    output req1_ready, rsp1_valid, rsp1_rdata,
    output mem_addr, mem_wdata, mem_we,
    input  mem_rdata
  );

  modport master (
    output req0_valid, req0_addr, req0_wdata, req0_we,
    input  req0_ready, rsp0_valid, rsp0_rdata,
    output req1_valid, req1_addr, req1_wdata, req1_we,
    input  req1_ready, rsp1_valid, rsp1_rdata,
    input  mem_addr, mem_wdata, mem_we,
    output mem_rdata
  );
endinterface

// File: rtl/dmem_arbiter.sv
// Round-robin two-port arbiter for a single-port data memory, one transaction in flight.
// Response pulse LAT+1 cycles after handshake; both readies are withheld until the response cycle has passed.
module dmem_arbiter #(
  parameter int AW  = 32,
  parameter int DW  = 32,
  parameter int LAT = 1
) (
  input logic           clk,
  input logic           rst_n,
  dmem_arbiter_if.slave bus
);
  localparam int            CW    = $clog2(LAT + 2);
  localparam logic [CW-1:0] LAT_C = CW'(LAT);

  typedef enum logic [1:0] {ST_IDLE, ST_ACCESS, ST_WAIT, ST_RESP} state_t;

  state_t        state_q;
  logic          last_grant_q;
  logic          port_q;
  logic          we_q;
  logic [CW-1:0] cnt_q;
  logic [AW-1:0] mem_addr_q;
  logic [DW-1:0] mem_wdata_q;
  logic          mem_we_q;
  logic          rsp0_valid_q;
  logic          rsp1_valid_q;
  logic [DW-1:0] rsp0_rdata_q;
  logic [DW-1:0] rsp1_rdata_q;

  logic          win0;
  logic          win1;
  logic          grant;
  logic          to_resp;
  logic [DW-1:0] rdata_d;

  // A tie goes to the port that did not win last time; ready is gated by rst_n so reset forces it low.
  assign win0    = bus.req0_valid && (!bus.req1_valid || last_grant_q);
  assign win1    = bus.req1_valid && (!bus.req0_valid || !last_grant_q);
  assign grant   = rst_n && (state_q == ST_IDLE) && (win0 || win1);
  assign to_resp = ((state_q == ST_ACCESS) && (LAT == 1)) ||
                   ((state_q == ST_WAIT) && (cnt_q == LAT_C));
  assign rdata_d = we_q ? '0 : bus.mem_rdata;

  assign bus.req0_ready = grant && win0;
  assign bus.req1_ready = grant && win1;
  assign bus.rsp0_valid = rsp0_valid_q;
  assign bus.rsp1_valid = rsp1_valid_q;
  assign bus.rsp0_rdata = rsp0_rdata_q;
  assign bus.rsp1_rdata = rsp1_rdata_q;
  assign bus.mem_addr   = mem_addr_q;
  assign bus.mem_wdata  = mem_wdata_q;
  assign bus.mem_we     = mem_we_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      last_grant_q <= 1'b1;
      port_q       <= 1'b0;
      we_q         <= 1'b0;
      cnt_q        <= '0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      mem_we_q     <= 1'b0;
      rsp0_valid_q <= 1'b0;
      rsp1_valid_q <= 1'b0;
      rsp0_rdata_q <= '0;
      rsp1_rdata_q <= '0;
    end else begin
      mem_we_q     <= 1'b0;
      rsp0_valid_q <= 1'b0;
      rsp1_valid_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (grant) begin
            // The memory-side registers double as the request latch.
            port_q       <= win1;
            last_grant_q <= win1;
            we_q         <= win1 ? bus.req1_we    : bus.req0_we;
            mem_addr_q   <= win1 ? bus.req1_addr  : bus.req0_addr;
            mem_wdata_q  <= win1 ? bus.req1_wdata : bus.req0_wdata;
            mem_we_q     <= win1 ? bus.req1_we    : bus.req0_we;
            cnt_q        <= CW'(1);
            state_q      <= ST_ACCESS;
          end
        end
        ST_ACCESS, ST_WAIT: begin
          cnt_q <= cnt_q + CW'(1);
          if (to_resp) begin
            state_q <= ST_RESP;
            if (port_q) begin
              rsp1_valid_q <= 1'b1;
              rsp1_rdata_q <= rdata_d;
            end else begin
              rsp0_valid_q <= 1'b1;
              rsp0_rdata_q <= rdata_d;
            end
          end else begin
            state_q <= ST_WAIT;
          end
        end
        ST_RESP: state_q <= ST_IDLE;
        default: state_q <= ST_IDLE;
      endcase
    end
  end
endmodule
